// File: rtl/core_hci_bridge.sv
// OBI-style core data port to single HCI master port, with in-order response tracking.
// Optional macro CORE_HCI_BRIDGE_RANGE_CHK_EN answers atomics and out-of-window accesses locally with an error.

module core_hci_bridge_chk (
    input  logic clk_i,
    input  logic rst_i,
    input  logic head_err_i,
    input  logic r_valid_i
);
    // The memory cannot owe a response ahead of a locally answered entry
    a_no_rsp_on_local_err: assert property (@(posedge clk_i) disable iff (rst_i)
        !(head_err_i && r_valid_i));
endmodule

module core_hci_bridge #(
    parameter int                MAX_OUTSTANDING = 2,
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 32,
    parameter logic [ADDR_W-1:0] WIN_BASE        = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] WIN_SIZE        = ADDR_W'(32'h0010_0000)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                core_req_i,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic                core_we_i,
    input  logic [DATA_W/8-1:0] core_be_i,
    input  logic [DATA_W-1:0]   core_wdata_i,
    input  logic [5:0]          core_atop_i,
    output logic                core_gnt_o,
    output logic                core_rvalid_o,
    output logic [DATA_W-1:0]   core_rdata_o,
    output logic                core_err_o,
    output logic                core_exokay_o,
    output logic                hci_req_o,
    input  logic                hci_gnt_i,
    output logic [ADDR_W-1:0]   hci_add_o,
    output logic                hci_wen_o,
    output logic [DATA_W/8-1:0] hci_be_o,
    output logic [DATA_W-1:0]   hci_data_o,
    input  logic                hci_r_valid_i,
    input  logic [DATA_W-1:0]   hci_r_data_i
);
    localparam int               PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_W:0]  WIN_LO  = {1'b0, WIN_BASE};
    localparam logic [ADDR_W:0]  WIN_SZ  = {1'b0, WIN_SIZE};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (MAX_OUTSTANDING == 1) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             err_q [MAX_OUTSTANDING];
    logic             err_d [MAX_OUTSTANDING];
    logic             we_q  [MAX_OUTSTANDING];
    logic             we_d  [MAX_OUTSTANDING];
    logic             illegal_s, full_s, empty_s, push_s, pop_s;
    logic             head_err_s, head_we_s, fwd_rsp_s;

`ifdef CORE_HCI_BRIDGE_RANGE_CHK_EN
    // Offset from base at ADDR_W+1 bits: addresses below base wrap high and fail the size compare
    assign illegal_s = (core_atop_i != 6'd0) |
                       (({1'b0, core_addr_i} - WIN_LO) >= WIN_SZ);
`else
    logic unused_cfg_s;
    assign illegal_s    = 1'b0;
    assign unused_cfg_s = ^{core_atop_i, WIN_LO, WIN_SZ};
`endif

    // Request side: grant depends only on registered occupancy
    always_comb begin
        full_s     = (cnt_q == CNT_MAX);
        hci_req_o  = core_req_i & ~full_s & ~illegal_s;
        core_gnt_o = illegal_s ? (core_req_i & ~full_s) : (hci_req_o & hci_gnt_i);
        push_s     = core_req_i & core_gnt_o;
        hci_add_o  = core_addr_i;
        hci_wen_o  = ~core_we_i;
        hci_be_o   = core_be_i;
        hci_data_o = core_wdata_i;
    end

    // Response side: head entry decides between local error and memory response
    always_comb begin
        empty_s       = (cnt_q == {CNT_W{1'b0}});
        head_err_s    = ~empty_s & err_q[rd_ptr_q];
        head_we_s     = we_q[rd_ptr_q];
        fwd_rsp_s     = ~empty_s & ~err_q[rd_ptr_q] & hci_r_valid_i;
        pop_s         = head_err_s | fwd_rsp_s;
        core_rvalid_o = pop_s;
        core_err_o    = head_err_s;
        core_exokay_o = 1'b0;
        if (fwd_rsp_s & ~head_we_s) begin
            core_rdata_o = hci_r_data_i;
        end else begin
            core_rdata_o = {DATA_W{1'b0}};
        end
    end

    // Tracking FIFO next state
    always_comb begin
        err_d    = err_q;
        we_d     = we_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            err_d[wr_ptr_q] = illegal_s;
            we_d[wr_ptr_q]  = core_we_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= {CNT_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            err_q    <= '{default: 1'b0};
            we_q     <= '{default: 1'b0};
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
            we_q     <= we_d;
        end
    end

    core_hci_bridge_chk u_chk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .head_err_i (head_err_s),
        .r_valid_i  (hci_r_valid_i)
    );
endmodule

// File: tb/tb_core_hci_bridge.sv
// Directed bench for core_hci_bridge with default parameters (MAX_OUTSTANDING = 2).

module tb_core_hci_bridge;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic [31:0] core_addr_i;
    logic        core_we_i;
    logic [3:0]  core_be_i;
    logic [31:0] core_wdata_i;
    logic [5:0]  core_atop_i;
    logic        core_gnt_o, core_rvalid_o, core_err_o, core_exokay_o;
    logic [31:0] core_rdata_o;
    logic        hci_req_o, hci_gnt_i, hci_wen_o, hci_r_valid_i;
    logic [31:0] hci_add_o, hci_data_o, hci_r_data_i;
    logic [3:0]  hci_be_o;

    int n_cmp = 0;
    int n_bad = 0;

    core_hci_bridge dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .core_req_i    (core_req_i),
        .core_addr_i   (core_addr_i),
        .core_we_i     (core_we_i),
        .core_be_i     (core_be_i),
        .core_wdata_i  (core_wdata_i),
        .core_atop_i   (core_atop_i),
        .core_gnt_o    (core_gnt_o),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .core_err_o    (core_err_o),
        .core_exokay_o (core_exokay_o),
        .hci_req_o     (hci_req_o),
        .hci_gnt_i     (hci_gnt_i),
        .hci_add_o     (hci_add_o),
        .hci_wen_o     (hci_wen_o),
        .hci_be_o      (hci_be_o),
        .hci_data_o    (hci_data_o),
        .hci_r_valid_i (hci_r_valid_i),
        .hci_r_data_i  (hci_r_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge and clear all stimulus
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
        core_req_i    = 1'b0;
        core_addr_i   = 32'h0;
        core_we_i     = 1'b0;
        core_be_i     = 4'hF;
        core_wdata_i  = 32'h0;
        core_atop_i   = 6'd0;
        hci_gnt_i     = 1'b0;
        hci_r_valid_i = 1'b0;
        hci_r_data_i  = 32'h0;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic we, input logic [5:0] atop, input logic gnt);
        core_req_i  = 1'b1;
        core_addr_i = addr;
        core_we_i   = we;
        core_atop_i = atop;
        hci_gnt_i   = gnt;
    endtask

    task automatic drive_rsp(input logic [31:0] data);
        hci_r_valid_i = 1'b1;
        hci_r_data_i  = data;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b1;
        sample();
        check_eq("rst_gnt", core_gnt_o, 1'b0);
        check_eq("rst_rvalid", core_rvalid_o, 1'b0);
        check_eq("rst_hci_req", hci_req_o, 1'b0);
        check_eq("rst_rdata", core_rdata_o, 32'h0);
        check_eq("rst_err", core_err_o, 1'b0);
        check_eq("rst_exokay", core_exokay_o, 1'b0);
        next_cycle();
        rst_i = 1'b0;

        // single read, response two cycles after the grant
        drive_req(32'h100, 1'b0, 6'd0, 1'b1);
        sample();
        check_eq("rd_hci_req", hci_req_o, 1'b1);
        check_eq("rd_gnt", core_gnt_o, 1'b1);
        check_eq("rd_add", hci_add_o, 32'h100);
        check_eq("rd_wen", hci_wen_o, 1'b1);
        next_cycle();
        sample();
        check_eq("rd_wait_rvalid", core_rvalid_o, 1'b0);
        next_cycle();
        drive_rsp(32'hDEADBEEF);
        sample();
        check_eq("rd_rvalid", core_rvalid_o, 1'b1);
        check_eq("rd_rdata", core_rdata_o, 32'hDEADBEEF);
        check_eq("rd_err", core_err_o, 1'b0);

        // write: fields pass through, response data is zero
        next_cycle();
        drive_req(32'h40, 1'b1, 6'd0, 1'b1);
        core_be_i    = 4'b0011;
        core_wdata_i = 32'h1234;
        sample();
        check_eq("wr_wen", hci_wen_o, 1'b0);
        check_eq("wr_be", hci_be_o, 4'b0011);
        check_eq("wr_data", hci_data_o, 32'h1234);
        check_eq("wr_gnt", core_gnt_o, 1'b1);
        next_cycle();
        drive_rsp(32'hFFFF_FFFF);
        sample();
        check_eq("wr_rvalid", core_rvalid_o, 1'b1);
        check_eq("wr_rdata", core_rdata_o, 32'h0);

        // fill to two outstanding, third request blocked even with a pop in the same cycle
        next_cycle();
        drive_req(32'h200, 1'b0, 6'd0, 1'b1);
        next_cycle();
        drive_req(32'h204, 1'b0, 6'd0, 1'b1);
        next_cycle();
        drive_req(32'h208, 1'b0, 6'd0, 1'b1);
        sample();
        check_eq("full_gnt", core_gnt_o, 1'b0);
        check_eq("full_hci_req", hci_req_o, 1'b0);
        next_cycle();
        drive_req(32'h208, 1'b0, 6'd0, 1'b1);
        drive_rsp(32'hA);
        sample();
        check_eq("full_pop_gnt", core_gnt_o, 1'b0);
        check_eq("full_pop_rvalid", core_rvalid_o, 1'b1);
        check_eq("full_pop_rdata", core_rdata_o, 32'hA);
        next_cycle();
        drive_req(32'h208, 1'b0, 6'd0, 1'b1);
        sample();
        check_eq("after_pop_gnt", core_gnt_o, 1'b1);
        check_eq("after_pop_hci_req", hci_req_o, 1'b1);
        next_cycle();
        drive_rsp(32'hB);
        sample();
        check_eq("drain1_rdata", core_rdata_o, 32'hB);
        next_cycle();
        drive_rsp(32'hC);
        sample();
        check_eq("drain2_rvalid", core_rvalid_o, 1'b1);
        check_eq("drain2_rdata", core_rdata_o, 32'hC);

        // memory withholds grant; nothing pushed, so a later stray response is dropped
        next_cycle();
        drive_req(32'h300, 1'b0, 6'd0, 1'b0);
        sample();
        check_eq("nogrant_hci_req", hci_req_o, 1'b1);
        check_eq("nogrant_gnt", core_gnt_o, 1'b0);
        next_cycle();
        drive_rsp(32'h77);
        sample();
        check_eq("empty_stray_rvalid", core_rvalid_o, 1'b0);

`ifdef CORE_HCI_BRIDGE_RANGE_CHK_EN
        // out-of-window read behind a forwarded read
        next_cycle();
        drive_req(32'h100, 1'b0, 6'd0, 1'b1);
        next_cycle();
        drive_req(32'h200000, 1'b0, 6'd0, 1'b1);
        sample();
        check_eq("oow_hci_req", hci_req_o, 1'b0);
        check_eq("oow_gnt", core_gnt_o, 1'b1);
        next_cycle();
        sample();
        check_eq("oow_wait_rvalid", core_rvalid_o, 1'b0);
        next_cycle();
        drive_rsp(32'h5A5A);
        sample();
        check_eq("oow_fwd_rvalid", core_rvalid_o, 1'b1);
        check_eq("oow_fwd_err", core_err_o, 1'b0);
        check_eq("oow_fwd_rdata", core_rdata_o, 32'h5A5A);
        next_cycle();
        sample();
        check_eq("oow_err_rvalid", core_rvalid_o, 1'b1);
        check_eq("oow_err_err", core_err_o, 1'b1);
        check_eq("oow_err_rdata", core_rdata_o, 32'h0);
        // atomic opcode answered locally
        next_cycle();
        drive_req(32'h100, 1'b0, 6'h23, 1'b1);
        sample();
        check_eq("atop_hci_req", hci_req_o, 1'b0);
        check_eq("atop_gnt", core_gnt_o, 1'b1);
        next_cycle();
        sample();
        check_eq("atop_rvalid", core_rvalid_o, 1'b1);
        check_eq("atop_err", core_err_o, 1'b1);
`else
        // without the range check, atomics and far addresses are forwarded
        next_cycle();
        drive_req(32'h200000, 1'b0, 6'h23, 1'b1);
        sample();
        check_eq("atop_hci_req", hci_req_o, 1'b1);
        check_eq("atop_gnt", core_gnt_o, 1'b1);
        next_cycle();
        drive_rsp(32'h55);
        sample();
        check_eq("atop_rvalid", core_rvalid_o, 1'b1);
        check_eq("atop_err", core_err_o, 1'b0);
        check_eq("atop_rdata", core_rdata_o, 32'h55);
`endif

        // reset with two reads in flight
        next_cycle();
        drive_req(32'h400, 1'b0, 6'd0, 1'b1);
        next_cycle();
        drive_req(32'h404, 1'b0, 6'd0, 1'b1);
        next_cycle();
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        drive_rsp(32'h99);
        sample();
        check_eq("mid_rst_stray_rvalid", core_rvalid_o, 1'b0);
        next_cycle();
        drive_req(32'h500, 1'b0, 6'd0, 1'b1);
        sample();
        check_eq("mid_rst_gnt1", core_gnt_o, 1'b1);
        next_cycle();
        drive_req(32'h504, 1'b0, 6'd0, 1'b1);
        sample();
        check_eq("mid_rst_gnt2", core_gnt_o, 1'b1);
        next_cycle();
        drive_rsp(32'h1111);
        sample();
        check_eq("mid_rst_rdata", core_rdata_o, 32'h1111);
        next_cycle();
        drive_rsp(32'h2222);
        sample();
        check_eq("mid_rst_rdata2", core_rdata_o, 32'h2222);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
